// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS multiply/divide engine: op codes, FSM states
// and the iteration counter width.
package mips_pkg;

   localparam int MD_WIDTH   = 32;
   localparam int ITER_CNT_W = $clog2(MD_WIDTH) + 1;

   localparam logic [2:0] OP_MULT  = 3'd0;
   localparam logic [2:0] OP_MULTU = 3'd1;
   localparam logic [2:0] OP_MADD  = 3'd2;
   localparam logic [2:0] OP_MSUB  = 3'd3;
   localparam logic [2:0] OP_DIV   = 3'd4;
   localparam logic [2:0] OP_DIVU  = 3'd5;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_PREP = 2'd1,
      S_ITER = 2'd2,
      S_FIX  = 2'd3
   } md_state_t;

   function automatic logic op_is_signed(input logic [2:0] op);
      return (op == OP_MULT) || (op == OP_MADD) || (op == OP_MSUB) || (op == OP_DIV);
   endfunction

   function automatic logic op_is_div(input logic [2:0] op);
      return (op == OP_DIV) || (op == OP_DIVU);
   endfunction

endpackage

// File: rtl/md_datapath.sv
// Operand latches, 2*WIDTH accumulator/remainder register, one shift-add or
// restoring shift-subtract step per cycle, and the final sign-fix/accumulate adder.
module md_datapath
   import mips_pkg::*;
#(
   parameter int WIDTH = MD_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             prep,
   input  logic             step,
   input  logic             fix,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic [WIDTH-1:0] hi_acc_in,
   input  logic [WIDTH-1:0] lo_acc_in,
   output logic [WIDTH-1:0] hi_result,
   output logic [WIDTH-1:0] lo_result
);

   localparam int W2 = 2 * WIDTH;

   logic [WIDTH-1:0] a_q, b_q, hacc_q, lacc_q;
   logic             neg_q, rem_neg_q;
   logic [W2-1:0]    acc;

   logic             is_signed, is_div;
   logic [WIDTH-1:0] a_mag, b_mag;
   logic [WIDTH:0]   sum, rp, diff;
   logic [W2-1:0]    mult_next, div_next, prod_s, mac;
   logic [WIDTH-1:0] quo_fix, rem_fix;

   function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
      return v[WIDTH-1] ? -v : v;
   endfunction

   function automatic logic [WIDTH-1:0] negate_if(input logic n, input logic [WIDTH-1:0] v);
      return n ? -v : v;
   endfunction

   always_comb begin
      is_signed = op_is_signed(op);
      is_div    = op_is_div(op);
      a_mag     = is_signed ? mag(a_q) : a_q;
      b_mag     = is_signed ? mag(b_q) : b_q;

      // Multiply: conditional add into the upper half, then shift right with the carry.
      sum       = {1'b0, acc[W2-1:WIDTH]} + (acc[0] ? {1'b0, a_q} : '0);
      mult_next = {sum, acc[WIDTH-1:1]};

      // Divide: shift remainder/quotient left, subtract divisor when no borrow.
      rp        = acc[W2-1:WIDTH-1];
      diff      = rp - {1'b0, b_q};
      div_next  = diff[WIDTH] ? {rp[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                              : {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

      prod_s    = neg_q ? -acc : acc;
      mac       = prod_s;
      if (op == OP_MADD) mac = {hacc_q, lacc_q} + prod_s;
      else if (op == OP_MSUB) mac = {hacc_q, lacc_q} - prod_s;

      quo_fix   = (b_q == '0) ? '1 : negate_if(neg_q, acc[WIDTH-1:0]);
      rem_fix   = negate_if(rem_neg_q, acc[W2-1:WIDTH]);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         a_q       <= '0;
         b_q       <= '0;
         hacc_q    <= '0;
         lacc_q    <= '0;
         neg_q     <= 1'b0;
         rem_neg_q <= 1'b0;
         acc       <= '0;
         hi_result <= '0;
         lo_result <= '0;
      end else begin
         if (load) begin
            a_q    <= a_in;
            b_q    <= b_in;
            hacc_q <= hi_acc_in;
            lacc_q <= lo_acc_in;
         end
         if (prep) begin
            a_q       <= a_mag;
            b_q       <= b_mag;
            neg_q     <= is_signed & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
            rem_neg_q <= is_signed & a_q[WIDTH-1];
            acc       <= {{WIDTH{1'b0}}, (is_div ? a_mag : b_mag)};
         end
         if (step) acc <= is_div ? div_next : mult_next;
         if (fix) begin
            if (is_div) begin
               hi_result <= rem_fix;
               lo_result <= quo_fix;
            end else begin
               {hi_result, lo_result} <= mac;
            end
         end
      end
   end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide engine feeding HI/LO: FSM, iteration counter and
// busy/done handshake around md_datapath. Fixed 34-edge latency per op.
module mult_div_unit
   import mips_pkg::*;
#(
   parameter int WIDTH = MD_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] A_input,
   input  logic [WIDTH-1:0] B_input,
   input  logic [WIDTH-1:0] HI_acc,
   input  logic [WIDTH-1:0] LO_acc,
   output logic [WIDTH-1:0] HI_result,
   output logic [WIDTH-1:0] LO_result,
   output logic             busy,
   output logic             done
);

   md_state_t              state, state_n;
   logic [ITER_CNT_W-1:0]  count;
   logic [2:0]             op_q;
   logic                   load, prep, step, fix;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_IDLE;
         count <= '0;
         op_q  <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= state_n;
         busy  <= (state_n != S_IDLE);
         done  <= fix;
         if (load) op_q <= op;
         if (prep) count <= '0;
         else if (step) count <= count + 1'b1;
      end
   end

   always_comb begin
      state_n = state;
      load    = 1'b0;
      prep    = 1'b0;
      step    = 1'b0;
      fix     = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               load    = 1'b1;
               state_n = S_PREP;
            end
         end
         S_PREP: begin
            prep    = 1'b1;
            state_n = S_ITER;
         end
         S_ITER: begin
            step = 1'b1;
            if (count == ITER_CNT_W'(WIDTH - 1)) state_n = S_FIX;
         end
         S_FIX: begin
            fix     = 1'b1;
            state_n = S_IDLE;
         end
         default: state_n = S_IDLE;
      endcase
   end

   md_datapath #(.WIDTH(WIDTH)) u_datapath (
      .clk       (clk),
      .reset     (reset),
      .load      (load),
      .prep      (prep),
      .step      (step),
      .fix       (fix),
      .op        (op_q),
      .a_in      (A_input),
      .b_in      (B_input),
      .hi_acc_in (HI_acc),
      .lo_acc_in (LO_acc),
      .hi_result (HI_result),
      .lo_result (LO_result)
   );

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed and randomized bench for mult_div_unit against an arithmetic reference model.
module tb_mult_div_unit;

   logic        clk = 1'b0;
   logic        reset, start;
   logic [2:0]  op;
   logic [31:0] a, b, hacc, lacc;
   logic [31:0] hi_res, lo_res;
   logic        busy, done;

   int          tests = 0;
   int          fails = 0;
   logic [31:0] exp_hi, exp_lo, sv_hi, sv_lo;
   logic        seen;

   always #5 clk = ~clk;

   mult_div_unit dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .op        (op),
      .A_input   (a),
      .B_input   (b),
      .HI_acc    (hacc),
      .LO_acc    (lacc),
      .HI_result (hi_res),
      .LO_result (lo_res),
      .busy      (busy),
      .done      (done)
   );

   // Reference: returns {HI, LO} from plain 64-bit arithmetic.
   function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] x, y, h, l);
      longint      sp, q, rm;
      logic [63:0] r;
      sp = longint'($signed(x)) * longint'($signed(y));
      case (o)
         3'd0: r = sp;
         3'd2: r = {h, l} + sp;
         3'd3: r = {h, l} - sp;
         3'd4: begin
            if (y == 0) r = {x, 32'hFFFF_FFFF};
            else begin
               q  = longint'($signed(x)) / longint'($signed(y));
               rm = longint'($signed(x)) % longint'($signed(y));
               r  = {rm[31:0], q[31:0]};
            end
         end
         3'd5: r = (y == 0) ? {x, 32'hFFFF_FFFF} : {x % y, x / y};
         default: r = {32'b0, x} * {32'b0, y};
      endcase
      return r;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic launch(input logic [2:0] o, input logic [31:0] x, y, h, l);
      @(negedge clk);
      start = 1'b1; op = o; a = x; b = y; hacc = h; lacc = l;
      {exp_hi, exp_lo} = model(o, x, y, h, l);
      @(negedge clk);
      start = 1'b0; op = 3'($urandom); a = $urandom; b = $urandom;
      hacc = $urandom; lacc = $urandom;
      check("accept_busy", busy, 1);
   endtask

   task automatic wait_done(input string tag, input int glitch);
      int   k;
      logic busy_ok;
      busy_ok = 1'b1;
      for (k = 1; k <= 40; k++) begin
         if (k == glitch) begin start = 1'b1; op = 3'd4; a = 99; b = 7; end
         if (k == glitch + 1) start = 1'b0;
         @(negedge clk);
         if (done) break;
         if (!busy) busy_ok = 1'b0;
      end
      check({tag, "_latency"}, k, 34);
      check({tag, "_busy_during"}, busy_ok, 1);
      check({tag, "_busy_at_done"}, busy, 0);
      check({tag, "_hi"}, hi_res, exp_hi);
      check({tag, "_lo"}, lo_res, exp_lo);
      @(negedge clk);
      check({tag, "_done_one_cycle"}, done, 0);
      check({tag, "_hold"}, {hi_res, lo_res}, {exp_hi, exp_lo});
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0; hacc = '0; lacc = '0;
      repeat (2) @(negedge clk);
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      check("reset_hilo", {hi_res, lo_res}, 64'd0);
      reset = 1'b0;

      launch(3'd0, 32'hFFFF_FFFD, 32'd5, 32'd0, 32'd0);          wait_done("mult_neg", -1);
      launch(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0);  wait_done("multu_max", -1);
      launch(3'd2, 32'd1, 32'd1, 32'd0, 32'hFFFF_FFFF);          wait_done("madd_carry", -1);
      launch(3'd3, 32'hFFFF_FFFE, 32'd3, 32'd5, 32'd10);         wait_done("msub", -1);
      launch(3'd4, 32'hFFFF_FFF9, 32'd2, 32'd0, 32'd0);          wait_done("div_neg", -1);
      launch(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd0);  wait_done("div_ovf", -1);
      launch(3'd5, 32'd10, 32'd0, 32'd0, 32'd0);                 wait_done("divu_zero", -1);
      launch(3'd4, 32'hFFFF_FFF0, 32'd0, 32'd0, 32'd0);          wait_done("div_zero_neg", -1);
      launch(3'd7, 32'd6, 32'd7, 32'd0, 32'd0);                  wait_done("reserved", -1);

      // start pulse while busy must be ignored: exactly one done
      launch(3'd1, 32'd3, 32'd4, 32'd0, 32'd0);
      wait_done("ignore_busy", 10);
      seen = 1'b0;
      repeat (40) begin @(negedge clk); if (done) seen = 1'b1; end
      check("ignore_no_extra_done", seen, 0);

      // start held across the done edge: accepted one edge later
      launch(3'd0, 32'd7, 32'hFFFF_FFFA, 32'd0, 32'd0);
      sv_hi = exp_hi; sv_lo = exp_lo;
      repeat (33) @(negedge clk);
      start = 1'b1; op = 3'd5; a = 32'd100; b = 32'd7; hacc = 32'd0; lacc = 32'd0;
      @(negedge clk);
      check("b2b_first_done", done, 1);
      check("b2b_not_accepted", busy, 0);
      check("b2b_first_result", {hi_res, lo_res}, {sv_hi, sv_lo});
      @(negedge clk);
      check("b2b_accept_busy", busy, 1);
      check("b2b_accept_done", done, 0);
      start = 1'b0;
      {exp_hi, exp_lo} = model(3'd5, 32'd100, 32'd7, 32'd0, 32'd0);
      wait_done("b2b_second", -1);

      // reset in the middle of a DIVU
      launch(3'd5, 32'h1234_5678, 32'd3, 32'd0, 32'd0);
      repeat (19) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("midreset_busy", busy, 0);
      check("midreset_done", done, 0);
      check("midreset_hilo", {hi_res, lo_res}, 64'd0);
      reset = 1'b0;
      seen = 1'b0;
      repeat (40) begin @(negedge clk); if (done) seen = 1'b1; end
      check("midreset_no_done", seen, 0);
      launch(3'd0, 32'd2, 32'd2, 32'd0, 32'd0);
      wait_done("post_reset_mult", -1);

      for (int i = 0; i < 16; i++) begin
         logic [2:0]  ro;
         logic [31:0] rx, ry;
         ro = 3'($urandom_range(0, 7));
         rx = $urandom;
         ry = $urandom;
         if (i % 3 == 0) ry = 32'($urandom_range(1, 20));
         if (i % 5 == 0) ry = 32'd0;
         if (i % 7 == 1) ry = 32'hFFFF_FFFF;
         launch(ro, rx, ry, $urandom, $urandom);
         wait_done("random", -1);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
